// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter that serialises 32-bit read/write transactions
// onto an 8-bit external bus as ADDR(4) / CMD(1) / TURN(n, reads) / DATA(4) / DONE(1).
module mem_bus_arbiter #(
    parameter int unsigned TURNAROUND = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r0_ack,
    output logic        r1_ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [7:0]  pad_dout,
    input  logic [7:0]  pad_din,
    output logic [7:0]  pad_oe,
    output logic        pad_frame
);

    typedef enum logic [2:0] {StIdle, StAddr, StCmd, StTurn, StData, StDone} state_e;

    localparam logic [1:0] TurnLast = (TURNAROUND == 0) ? 2'd0 : 2'(TURNAROUND - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        grant_q, we_q, last_grant_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        any_req, winner;

    assign any_req = r0_req | r1_req;
    // On a tie the requester not granted last wins.
    assign winner  = (r0_req && r1_req) ? ~last_grant_q : r1_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = 2'd0;
                if (any_req) state_d = StAddr;
            end
            StAddr: begin
                if (cnt_q == 2'd3) begin
                    state_d = StCmd;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StCmd: begin
                cnt_d   = 2'd0;
                state_d = (we_q || TURNAROUND == 0) ? StData : StTurn;
            end
            StTurn: begin
                if (cnt_q == TurnLast) begin
                    state_d = StData;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StData: begin
                if (cnt_q == 2'd3) begin
                    state_d = StDone;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Transaction fields are frozen at grant so requester changes mid-flight are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            last_grant_q <= 1'b1;
            rdata_q      <= 32'h0;
        end else begin
            if (state_q == StIdle && any_req) begin
                grant_q      <= winner;
                last_grant_q <= winner;
                we_q         <= winner ? r1_we    : r0_we;
                addr_q       <= winner ? r1_addr  : r0_addr;
                wdata_q      <= winner ? r1_wdata : r0_wdata;
            end
            if (state_q == StData && !we_q) begin
                rdata_q[{cnt_q, 3'b000} +: 8] <= pad_din;
            end
        end
    end

    always_comb begin
        busy      = (state_q != StIdle);
        pad_frame = 1'b0;
        pad_oe    = 8'h00;
        pad_dout  = 8'h00;
        r0_ack    = 1'b0;
        r1_ack    = 1'b0;
        unique case (state_q)
            StIdle: ;
            StAddr: begin
                pad_frame = 1'b1;
                pad_oe    = 8'hFF;
                pad_dout  = addr_q[{cnt_q, 3'b000} +: 8];
            end
            StCmd: begin
                pad_frame = 1'b1;
                pad_oe    = 8'hFF;
                pad_dout  = {6'b0, grant_q, we_q};
            end
            StTurn: pad_frame = 1'b1;
            StData: begin
                pad_frame = 1'b1;
                if (we_q) begin
                    pad_oe   = 8'hFF;
                    pad_dout = wdata_q[{cnt_q, 3'b000} +: 8];
                end
            end
            StDone: begin
                r0_ack = ~grant_q;
                r1_ack = grant_q;
            end
            default: ;
        endcase
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: lane 0 uses TURNAROUND=1, lane 1 uses TURNAROUND=0.
// A transaction-level model predicts every cycle of pin activity for both lanes.
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic       busy;
        logic       frame;
        logic [7:0] oe;
        logic [7:0] dout;
        logic       ack0;
        logic       ack1;
        logic       cap;
        logic [1:0] k;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int ta [2] = '{1, 0};

    logic        rst_n;
    logic        req0 [2], req1 [2], we0 [2], we1 [2];
    logic [31:0] addr0 [2], addr1 [2], wd0 [2], wd1 [2];
    logic [7:0]  din [2];
    logic        ack0 [2], ack1 [2], busy [2], frame [2];
    logic [31:0] rdata [2];
    logic [7:0]  dout [2], oe [2];

    mem_bus_arbiter #(.TURNAROUND(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .r0_req(req0[0]), .r0_we(we0[0]), .r0_addr(addr0[0]), .r0_wdata(wd0[0]),
        .r1_req(req1[0]), .r1_we(we1[0]), .r1_addr(addr1[0]), .r1_wdata(wd1[0]),
        .r0_ack(ack0[0]), .r1_ack(ack1[0]), .rdata(rdata[0]), .busy(busy[0]),
        .pad_dout(dout[0]), .pad_din(din[0]), .pad_oe(oe[0]), .pad_frame(frame[0])
    );

    mem_bus_arbiter #(.TURNAROUND(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .r0_req(req0[1]), .r0_we(we0[1]), .r0_addr(addr0[1]), .r0_wdata(wd0[1]),
        .r1_req(req1[1]), .r1_we(we1[1]), .r1_addr(addr1[1]), .r1_wdata(wd1[1]),
        .r0_ack(ack0[1]), .r1_ack(ack1[1]), .rdata(rdata[1]), .busy(busy[1]),
        .pad_dout(dout[1]), .pad_din(din[1]), .pad_oe(oe[1]), .pad_frame(frame[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    exp_t       mq [2][$];
    logic [7:0] blog [2][$];
    logic       last_m [2];
    logic [31:0] rd_m [2];
    bit         armed = 1'b0;

    function automatic exp_t mk(input logic fr, input logic [7:0] o, input logic [7:0] d,
                                input logic a0, input logic a1, input logic cp,
                                input logic [1:0] k);
        exp_t x;
        x.busy = 1'b1; x.frame = fr; x.oe = o; x.dout = d;
        x.ack0 = a0; x.ack1 = a1; x.cap = cp; x.k = k;
        return x;
    endfunction

    // Expand a granted request into its full cycle-by-cycle pin schedule.
    task automatic build(input int l);
        logic        w, we;
        logic [31:0] a, wd;
        if (req0[l] && req1[l]) w = (last_m[l] == 1'b1) ? 1'b0 : 1'b1;
        else                    w = req1[l];
        last_m[l] = w;
        we = w ? we1[l]   : we0[l];
        a  = w ? addr1[l] : addr0[l];
        wd = w ? wd1[l]   : wd0[l];
        for (int i = 0; i < 4; i++) mq[l].push_back(mk(1, 8'hFF, a[8*i +: 8], 0, 0, 0, 2'd0));
        mq[l].push_back(mk(1, 8'hFF, {6'b0, w, we}, 0, 0, 0, 2'd0));
        if (!we) for (int i = 0; i < ta[l]; i++) mq[l].push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 2'd0));
        for (int i = 0; i < 4; i++) begin
            if (we) mq[l].push_back(mk(1, 8'hFF, wd[8*i +: 8], 0, 0, 0, 2'd0));
            else    mq[l].push_back(mk(1, 8'h00, 8'h00, 0, 0, 1, 2'(i)));
        end
        mq[l].push_back(mk(0, 8'h00, 8'h00, ~w, w, 0, 2'd0));
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int l = 0; l < 2; l++) begin
            e = (mq[l].size() > 0) ? mq[l][0] : '0;
            if (armed) begin
                chk($sformatf("lane%0d_pins", l),
                    64'({busy[l], frame[l], oe[l], dout[l], ack0[l], ack1[l]}),
                    64'({e.busy, e.frame, e.oe, e.dout, e.ack0, e.ack1}));
                chk($sformatf("lane%0d_rdata", l), 64'(rdata[l]), 64'(rd_m[l]));
                if (oe[l] == 8'hFF) blog[l].push_back(dout[l]);
            end
            if (!rst_n) begin
                mq[l].delete();
                last_m[l] = 1'b1;
                rd_m[l]   = 32'h0;
            end else if (mq[l].size() > 0) begin
                if (e.cap) rd_m[l][8*e.k +: 8] = din[l];
                void'(mq[l].pop_front());
            end else if (req0[l] || req1[l]) begin
                build(l);
            end
        end
        if (!rst_n) armed = 1'b1;
    end

    // ---------------- stimulus ----------------
    function automatic logic [71:0] pack9(input int l);
        logic [71:0] v;
        v = '0;
        for (int i = 0; i < 9; i++)
            if (i < blog[l].size()) v[71-8*i -: 8] = blog[l][i];
        return v;
    endfunction

    // Issue one request, drive read bytes on schedule, drop req the cycle after ack.
    task automatic run(input int l, input bit who, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] pat, output int at);
        int t, rc;
        @(posedge clk); #1;
        if (who) begin req1[l] = 1; we1[l] = we; addr1[l] = a; wd1[l] = wd; end
        else     begin req0[l] = 1; we0[l] = we; addr0[l] = a; wd0[l] = wd; end
        t  = cyc;
        at = -1;
        for (int n = 0; n < 40 && at < 0; n++) begin
            @(negedge clk);
            if ((who ? ack1[l] : ack0[l]) === 1'b1) at = cyc - t;
            @(posedge clk); #1;
            rc = cyc - t;
            if (rc >= 6 + ta[l] && rc <= 9 + ta[l]) din[l] = pat[8*(rc-6-ta[l]) +: 8];
            else                                     din[l] = 8'($urandom);
        end
        if (who) req1[l] = 0; else req0[l] = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int at, t, seen, nack;
        logic [2:0] order;
        rst_n = 1'b0;
        for (int l = 0; l < 2; l++) begin
            req0[l] = 0; req1[l] = 0; we0[l] = 0; we1[l] = 0;
            addr0[l] = 0; addr1[l] = 0; wd0[l] = 0; wd1[l] = 0; din[l] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", 64'(busy[0]), 64'(0));
        chk("reset_oe", 64'(oe[0]), 64'(0));
        chk("reset_rdata", 64'(rdata[0]), 64'(0));

        // Write from r0
        blog[0].delete();
        run(0, 0, 1, 32'h12345678, 32'hCAFEBABE, 32'h0, at);
        chk("wr_ack_latency", 64'(at), 64'(10));
        chk("wr_bytes", 64'(pack9(0) >> 8), 64'(72'h7856341201BEBAFECA >> 8));
        chk("wr_last_byte", 64'(pack9(0) & 72'hFF), 64'(8'hCA));

        // Read from r1, one turnaround cycle
        blog[0].delete();
        run(0, 1, 0, 32'h00000010, 32'h0, 32'hD4C3B2A1, at);
        chk("rd_ack_latency", 64'(at), 64'(11));
        chk("rd_rdata", 64'(rdata[0]), 64'(32'hD4C3B2A1));
        chk("rd_addr_cmd", 64'(pack9(0) >> 32), 64'(40'h1000000002));

        // Tie: both requesters held high for three transactions
        @(posedge clk); #1;
        req0[0] = 1; we0[0] = 1; addr0[0] = 32'h100; wd0[0] = 32'h11111111;
        req1[0] = 1; we1[0] = 1; addr1[0] = 32'h200; wd1[0] = 32'h22222222;
        nack = 0;
        order = '0;
        for (int c = 0; c < 80 && nack < 3; c++) begin
            @(negedge clk);
            chk("tie_overlap", 64'(ack0[0] & ack1[0]), 64'(0));
            if (ack0[0] || ack1[0]) begin
                order[2-nack] = ack1[0];
                nack++;
            end
        end
        @(posedge clk); #1;
        req0[0] = 0; req1[0] = 0;
        chk("tie_count", 64'(nack), 64'(3));
        chk("tie_order", 64'(order), 64'(3'b010));
        chk("rdata_hold", 64'(rdata[0]), 64'(32'hD4C3B2A1));

        // Stability: address changed and req dropped during ADDR byte 1
        blog[0].delete();
        @(posedge clk); #1;
        req0[0] = 1; we0[0] = 0; addr0[0] = 32'hAABBCCDD;
        t = cyc;
        while (cyc < t + 2) begin @(posedge clk); #1; end
        addr0[0] = 32'h0; req0[0] = 0;
        at = -1;
        for (int n = 0; n < 30 && at < 0; n++) begin
            @(negedge clk);
            if (ack0[0] === 1'b1) at = cyc - t;
        end
        chk("stab_ack_latency", 64'(at), 64'(11));
        chk("stab_nbytes", 64'(blog[0].size()), 64'(5));
        chk("stab_bytes", 64'(pack9(0) >> 32), 64'(40'hDDCCBBAA00));

        // Reset during DATA byte 2 of a write
        @(posedge clk); #1;
        req0[0] = 1; we0[0] = 1; addr0[0] = 32'hA0A0A0A0; wd0[0] = 32'h55667788;
        t = cyc;
        while (cyc < t + 8) begin @(posedge clk); #1; end
        rst_n = 1'b0; req0[0] = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_oe", 64'(oe[0]), 64'(0));
        chk("rst_mid_busy", 64'(busy[0]), 64'(0));
        chk("rst_mid_rdata", 64'(rdata[0]), 64'(0));
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (ack0[0] || ack1[0]) seen++;
        end
        chk("rst_no_ack", 64'(seen), 64'(0));
        run(0, 1, 1, 32'h00C0FFEE, 32'h01020304, 32'h0, at);
        chk("post_rst_ack_latency", 64'(at), 64'(10));

        // TURNAROUND=0 read on lane 1
        run(1, 0, 0, 32'h00000040, 32'h0, 32'h44332211, at);
        chk("ta0_ack_latency", 64'(at), 64'(10));
        chk("ta0_rdata", 64'(rdata[1]), 64'(32'h44332211));

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TURNAROUND, default 1: idle cycles between the CMD byte and the first read-data byte; legal range 0..3.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 r0_req / r1_req  in  1  transaction request from requester 0 / 1; held high until the matching ack.
REQ-005 r0_we / r1_we  in  1  1 = write, 0 = read.
REQ-006 r0_addr / r1_addr  in  32  byte address.
REQ-007 r0_wdata / r1_wdata  in  32  write data.
REQ-008 r0_ack / r1_ack  out  1  one-cycle completion pulse.
REQ-009 rdata  out  32  shared read-data register; valid when a read's ack is high.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 pad_dout  out  8  byte driven onto the external 8-bit bus.
REQ-012 pad_din  in  8  byte sampled from the external 8-bit bus.
REQ-013 pad_oe  out  8  pad output enable (all ones = drive, all zeros = tristate).
REQ-014 pad_frame  out  1  high from ADDR byte 0 through the last DATA byte.

Function
REQ-015 FSM states: IDLE, ADDR (4 cycles), CMD (1), TURN (TURNAROUND cycles, reads only), DATA (4), DONE (1).
REQ-016 Grant: in IDLE with at least one req high, latch winner id, we, addr and wdata; next state is ADDR.
REQ-017 Arbitration: a single requester wins; if both are high, the requester not granted last wins (round-robin); last_grant resets to 1 so r0 wins the first tie.
REQ-018 ADDR: pad_dout = addr bytes, LSB first (byte 0 = addr[7:0] ... byte 3 = addr[31:24]).
REQ-019 CMD: pad_dout = {6'b0, grant_id, we}.
REQ-020 Write path: CMD -> DATA; pad_dout = wdata bytes, LSB first.
REQ-021 Read path: CMD -> TURN (skipped when TURNAROUND=0) -> DATA; pad_din is captured at the end of each DATA cycle into rdata byte k, k = 0..3 LSB first.
REQ-022 pad_oe = 8'hFF in ADDR, CMD and write DATA; 8'h00 in IDLE, TURN, read DATA and DONE.
REQ-023 pad_dout = 8'h00 whenever pad_oe = 8'h00.
REQ-024 DONE: assert only the granted requester's ack for exactly one cycle, then return to IDLE.
REQ-025 Latency from req high in IDLE at cycle T:
 - ADDR at T+1..T+4, CMD at T+5.
 - Write: DATA at T+6..T+9, ack at T+10.
 - Read: DATA at T+6+TURNAROUND .. T+9+TURNAROUND, ack at T+10+TURNAROUND.
REQ-026 Latched fields are immune to requester input changes after grant; a req drop mid-transaction does not abort it, and ack is still issued.
REQ-027 Requesters deassert req in the cycle after ack; a req still high in the following IDLE cycle starts a new transaction.
REQ-028 At least one IDLE cycle separates consecutive transactions; back-to-back ties alternate r0, r1, r0, ...
REQ-029 rdata holds its value until the next read's DATA phase; writes never modify rdata.
REQ-030 The losing requester waits with no ack; it is never starved beyond one transaction.

Reset
REQ-031 rst_n low at a rising edge forces the following state on the next cycle, from any state:
 - state = IDLE, last_grant = 1;
 - r0_ack = r1_ack = 0, busy = 0, pad_frame = 0;
 - pad_oe = 8'h00, pad_dout = 8'h00, rdata = 32'h0.
REQ-032 A transaction interrupted by reset is dropped silently: no ack is issued, and it is not resumed.

Verification
REQ-033 Write: r0 write, addr 0x12345678, wdata 0xCAFEBABE -> pad_dout 78,56,34,12,01,BE,BA,FE,CA with oe=FF, then r0_ack at T+10.
REQ-034 Read, TURNAROUND=1: r1 read, addr 0x00000010, pad_din A1,B2,C3,D4 -> CMD 02, one tristate cycle, r1_ack at T+11, rdata = 0xD4C3B2A1.
REQ-035 Tie: r0 and r1 held high continuously for 3 transactions -> grant order r0, r1, r0, with no overlapping acks.
REQ-036 Reset mid-operation: rst_n low during DATA byte 2 of a write -> IDLE next cycle, oe=00, no ack; a fresh r1 request then completes normally.
REQ-037 TURNAROUND=0 read -> DATA immediately follows CMD, ack at T+10.
REQ-038 Stability: r0_addr changed and r0_req dropped during ADDR byte 1 -> original address bytes still emitted and ack still pulsed.
